// File: rtl/card_deal_sequencer.sv
// Draws cards from card_rng and routes them to the player or dealer hand.
// Shoe tracking (rank counts, cards_left, reshuffle) is enabled by DEAL_SHOE_TRACK_EN.
module card_deal_sequencer #(
  parameter int SETTLE_CYCLES    = 4,
  parameter int RESHUFFLE_THRESH = 12
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rng_value,
  input  logic       deal_start,
  input  logic       player_hit,
  input  logic       dealer_hit,
  input  logic       shuffle,
  output logic       busy,
  output logic       card_valid,
  output logic       card_to_dealer,
  output logic [3:0] card_rank,
  output logic [3:0] card_points,
  output logic       card_is_ace,
  output logic       hole_card,
  output logic       deal_done,
  output logic       reshuffled,
  output logic [5:0] cards_left
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DRAW, S_EMIT} state_e;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       deal_q, deal_d;
  logic       dest_q, dest_d;
  logic [3:0] rank_q, rank_d;
  logic [3:0] pts_q, pts_d;
  logic       ace_q, ace_d;
  logic       todlr_q, todlr_d;

  logic       legal_w, take_w, reshuf_w;
  logic       shuf_req_w, thr_low_w, empty_w;

  assign legal_w = (rng_value >= 4'd1) && (rng_value <= 4'd13);

`ifdef DEAL_SHOE_TRACK_EN
  logic [12:0][2:0] rcnt_q, rcnt_d;
  logic [5:0]       left_q, left_d;
  logic [2:0]       sel_cnt;

  always_comb begin
    sel_cnt = 3'd0;
    for (int i = 0; i < 13; i++)
      if (rng_value == 4'(i + 1)) sel_cnt = rcnt_q[i];
  end

  assign take_w     = legal_w && (sel_cnt != 3'd4);
  assign shuf_req_w = shuffle;
  assign thr_low_w  = int'(left_q) < RESHUFFLE_THRESH;
  assign empty_w    = (left_q == 6'd0);

  always_comb begin
    rcnt_d = rcnt_q;
    left_d = left_q;
    if (reshuf_w) begin
      rcnt_d = '0;
      left_d = 6'd52;
    end else if (state_q == S_DRAW && take_w) begin
      for (int i = 0; i < 13; i++)
        if (rng_value == 4'(i + 1) && rcnt_q[i] != 3'd4) rcnt_d[i] = rcnt_q[i] + 3'd1;
      left_d = left_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '0;
      left_q <= 6'd52;
    end else begin
      rcnt_q <= rcnt_d;
      left_q <= left_d;
    end
  end

  assign cards_left = left_q;
`else
  // Infinite deck: every legal rank is always available and the shoe never empties.
  logic unused_shuffle;
  assign unused_shuffle = shuffle ^ (RESHUFFLE_THRESH == 0);
  assign take_w     = legal_w;
  assign shuf_req_w = 1'b0;
  assign thr_low_w  = 1'b0;
  assign empty_w    = 1'b0;
  assign cards_left = 6'd52;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      deal_q  <= 1'b0;
      dest_q  <= 1'b0;
      rank_q  <= '0;
      pts_q   <= '0;
      ace_q   <= 1'b0;
      todlr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      deal_q  <= deal_d;
      dest_q  <= dest_d;
      rank_q  <= rank_d;
      pts_q   <= pts_d;
      ace_q   <= ace_d;
      todlr_q <= todlr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    deal_d   = deal_q;
    dest_d   = dest_q;
    rank_d   = rank_q;
    pts_d    = pts_q;
    ace_d    = ace_q;
    todlr_d  = todlr_q;
    reshuf_w = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (shuf_req_w) begin
          reshuf_w = 1'b1;
        end else if (deal_start) begin
          reshuf_w = thr_low_w;
          deal_d   = 1'b1;
          idx_d    = 2'd0;
          cnt_d    = SETTLE_LOAD;
          state_d  = S_SETTLE;
        end else if (player_hit || dealer_hit) begin
          reshuf_w = empty_w;
          deal_d   = 1'b0;
          dest_d   = !player_hit;
          cnt_d    = SETTLE_LOAD;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) state_d = S_DRAW;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DRAW: begin
        if (take_w) begin
          rank_d  = rng_value;
          pts_d   = (rng_value > 4'd10) ? 4'd10 : rng_value;
          ace_d   = (rng_value == 4'd1);
          todlr_d = deal_q ? idx_q[0] : dest_q;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (deal_q && idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    card_valid = (state_q == S_EMIT);
    hole_card  = card_valid && deal_q && (idx_q == 2'd3);
    deal_done  = hole_card;
    reshuffled = reshuf_w;
  end

  assign card_to_dealer = todlr_q;
  assign card_rank      = rank_q;
  assign card_points    = pts_q;
  assign card_is_ace    = ace_q;

endmodule

// File: tb/tb_card_deal_sequencer.sv
// Self-checking bench for card_deal_sequencer: vector table, scripted corners,
// randomized requests against a shoe model; adapts to DEAL_SHOE_TRACK_EN.
module tb_card_deal_sequencer;
  localparam int S      = 4;
  localparam int THRESH = 12;
`ifdef DEAL_SHOE_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, deal_start, player_hit, dealer_hit, shuffle;
  logic [3:0] rng_value;
  logic       busy, card_valid, card_to_dealer, card_is_ace, hole_card, deal_done, reshuffled;
  logic [3:0] card_rank, card_points;
  logic [5:0] cards_left;

  card_deal_sequencer #(.SETTLE_CYCLES(S), .RESHUFFLE_THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .rng_value(rng_value), .deal_start(deal_start),
    .player_hit(player_hit), .dealer_hit(dealer_hit), .shuffle(shuffle),
    .busy(busy), .card_valid(card_valid), .card_to_dealer(card_to_dealer),
    .card_rank(card_rank), .card_points(card_points), .card_is_ace(card_is_ace),
    .hole_card(hole_card), .deal_done(deal_done), .reshuffled(reshuffled),
    .cards_left(cards_left));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int mcnt [0:15];
  int mleft;
  int rng_q [$];
  int rng_hold = 0;
  bit rand_mode = 1'b0;

  typedef struct {
    int kind; int nbad; int badv; int v;
    int rank; int pts; int ace; int dest; int lat;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reshuffle();
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    mleft = 52;
  endtask

  function automatic bit accepts(input int v);
    if (v < 1 || v > 13) return 1'b0;
    return !TRK || mcnt[v] < 4;
  endfunction

  task automatic pick(output int v);
    if (rng_q.size() > 0) begin
      v = rng_q.pop_front();
      rng_hold = v;
    end else if (rand_mode) v = int'($urandom_range(0, 15));
    else v = rng_hold;
  endtask

  // Issue one request from an IDLE cycle and follow it to completion.
  // extra: bit0 simultaneous dealer_hit, bit1 dealer_hit while busy, bit2 simultaneous shuffle.
  task automatic request(input int kind, input int extra, output int lat, output bit resh);
    int t, v, nc, d;
    bit shuf_win, got, exp_dest;
    lat = 0; resh = 1'b0; t = 0; v = 0;
    deal_start = (kind == 0);
    player_hit = (kind == 1);
    dealer_hit = (kind == 2) || extra[0];
    shuffle    = (kind == 3) || extra[2];
    #1;
    shuf_win = TRK && shuffle;
    if (shuf_win) resh = 1'b1;
    else if (kind == 0) resh = TRK && (mleft < THRESH);
    else if (kind != 3) resh = TRK && (mleft == 0);
    chk("reshuffled", reshuffled, resh);
    if (resh) model_reshuffle();
    cyc(); t = 1;
    deal_start = 0; player_hit = 0; dealer_hit = 0; shuffle = 0;
    chk("cards_left_accept", cards_left, mleft);
    if (shuf_win || kind == 3) begin
      chk("busy_after_shuffle", busy, 0);
      return;
    end
    nc = (kind == 0) ? 4 : 1;
    for (int c = 0; c < nc; c++) begin
      for (int s = 0; s < S; s++) begin
        if (!(c == 0 && s == 0)) begin cyc(); t++; end
        rng_value  = 4'($urandom_range(0, 15));
        dealer_hit = extra[1] && c == 0 && s == 1;
        #1;
        chk("busy_settle", busy, 1);
        chk("valid_settle", card_valid, 0);
      end
      dealer_hit = 0;
      got = 1'b0;
      for (d = 0; d < 200 && !got; d++) begin
        cyc(); t++;
        pick(v);
        rng_value = 4'(v);
        #1;
        chk("busy_draw", busy, 1);
        chk("valid_draw", card_valid, 0);
        got = accepts(v);
      end
      if (!got) begin
        chk("draw_timeout", 0, 1);
        return;
      end
      mcnt[v]++;
      if (TRK) mleft--;
      exp_dest = (kind == 0) ? c[0] : (kind == 2);
      cyc(); t++;
      rng_value = 4'($urandom_range(0, 15));
      #1;
      chk("card_valid", card_valid, 1);
      chk("card_to_dealer", card_to_dealer, exp_dest);
      chk("card_rank", card_rank, v);
      chk("card_points", card_points, (v > 10) ? 10 : v);
      chk("card_is_ace", card_is_ace, v == 1);
      chk("hole_card", hole_card, kind == 0 && c == 3);
      chk("deal_done", deal_done, kind == 0 && c == 3);
      chk("cards_left_emit", cards_left, mleft);
      lat = t;
    end
    cyc();
    #1;
    chk("busy_end", busy, 0);
    chk("valid_end", card_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt;
    bit resh;
    tbl[0] = '{1, 3, 0,  12, 12, 10, 0, 0, 9};
    tbl[1] = '{2, 0, 0,   1,  1,  1, 1, 1, 6};
    tbl[2] = '{1, 1, 15, 10, 10, 10, 0, 0, 7};
    tbl[3] = '{2, 2, 14, 11, 11, 10, 0, 1, 8};
    tbl[4] = '{1, 0, 0,  13, 13, 10, 0, 0, 6};
    tbl[5] = '{2, 0, 0,   2,  2,  2, 0, 1, 6};
    tbl[6] = '{1, 1, 0,   9,  9,  9, 0, 0, 7};

    rst = 1; deal_start = 0; player_hit = 0; dealer_hit = 0; shuffle = 0; rng_value = 0;
    model_reshuffle();
    repeat (3) cyc();
    rst = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_cards_left", cards_left, 52);
    chk("rst_rank", card_rank, 0);
    chk("rst_points", card_points, 0);
    chk("rst_ace", card_is_ace, 0);
    chk("rst_dest", card_to_dealer, 0);
    chk("rst_hole", hole_card, 0);
    chk("rst_done", deal_done, 0);
    chk("rst_reshuffled", reshuffled, 0);

    for (int i = 0; i < 7; i++) begin
      rng_q.delete();
      for (int b = 0; b < tbl[i].nbad; b++) rng_q.push_back(tbl[i].badv);
      rng_q.push_back(tbl[i].v);
      request(tbl[i].kind, 0, lat, resh);
      chk("tbl_latency", lat, tbl[i].lat);
      chk("tbl_rank", card_rank, tbl[i].rank);
      chk("tbl_points", card_points, tbl[i].pts);
      chk("tbl_ace", card_is_ace, tbl[i].ace);
      chk("tbl_dest", card_to_dealer, tbl[i].dest);
    end

    // Opening deal with the RNG parked on 7.
    request(3, 0, lat, resh);
    chk("shuffle_left", cards_left, 52);
    rng_q.delete(); rng_q.push_back(7);
    request(0, 0, lat, resh);
    chk("deal_latency", lat, 24);
    chk("deal_rank", card_rank, 7);
    chk("deal_points", card_points, 7);
    chk("deal_left", cards_left, TRK ? 48 : 52);

    // Four aces, then a fifth ace attempt.
    request(3, 0, lat, resh);
    rng_q.delete(); rng_q.push_back(1);
    for (int i = 0; i < 4; i++) begin
      request(1 + (i % 2), 0, lat, resh);
      chk("ace_is_ace", card_is_ace, 1);
      chk("ace_points", card_points, 1);
    end
    rng_q.delete();
    rng_q.push_back(1); rng_q.push_back(1); rng_q.push_back(1); rng_q.push_back(2);
    request(1, 0, lat, resh);
    chk("fifth_rank", card_rank, TRK ? 2 : 1);
    chk("fifth_latency", lat, TRK ? 9 : 6);
    rng_q.delete();

    // Simultaneous player/dealer hit, plus a dealer hit while busy.
    rng_hold = 5;
    request(1, 3, lat, resh);
    chk("drop_dest", card_to_dealer, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      cnt += int'(busy) + int'(card_valid);
    end
    chk("drop_no_extra_card", cnt, 0);

    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 3));
      request(k, (k == 3) ? 0 : int'($urandom_range(0, 7)), lat, resh);
    end

    // Drain the shoe to 11 cards, then a deal must reshuffle first.
    if (mleft <= 11) request(3, 0, lat, resh);
    cnt = 0;
    while (mleft > (TRK ? 11 : 52) && cnt < 80) begin
      request(1 + int'($urandom_range(0, 1)), 0, lat, resh);
      cnt++;
    end
    chk("drain_left", cards_left, TRK ? 11 : 52);
    request(0, 0, lat, resh);
    chk("thresh_reshuffled", resh, TRK);
    chk("thresh_left", cards_left, TRK ? 48 : 52);

    // Reset in the middle of an opening deal.
    rand_mode = 1'b0; rng_hold = 6;
    deal_start = 1;
    repeat (10) begin cyc(); deal_start = 0; end
    rst = 1;
    cyc();
    rst = 0;
    model_reshuffle();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", card_valid, 0);
    chk("midrst_left", cards_left, 52);
    chk("midrst_rank", card_rank, 0);
    chk("midrst_points", card_points, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(); #1;
      cnt += int'(card_valid) + int'(deal_done) + int'(busy);
    end
    chk("midrst_quiet", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/card_deal_sequencer.md
# card_deal_sequencer

Sequences card draws from the free-running `card_rng` source and routes each card to the player or dealer hand for `blackjack_fsm`. It runs the four-card opening deal (P, D, P, D) and serves single-card hit requests from the player and dealer. It rejects out-of-range RNG samples, tracks a single 52-card shoe so no rank appears more than four times, and reshuffles automatically. It sits between `card_rng` and `blackjack_fsm` and is the only block allowed to consume RNG samples.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles waited before each draw so the RNG advances between cards. Legal range 1..255.
- `RESHUFFLE_THRESH`, default 12: a `deal_start` accepted with `cards_left` below this value reshuffles first.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rng_value` in 4: raw RNG sample. Legal ranks are 1..13; 0, 14 and 15 are rejected.
- `deal_start` in 1: one-cycle request for the opening deal.
- `player_hit` in 1: one-cycle request for one player card.
- `dealer_hit` in 1: one-cycle request for one dealer card.
- `shuffle` in 1: one-cycle request to restore the full shoe.
- `busy` out 1: high in every state except IDLE.
- `card_valid` out 1: one-cycle strobe; the card outputs below are valid in this cycle.
- `card_to_dealer` out 1: destination of the card (0 = player, 1 = dealer).
- `card_rank` out 4: rank, 1 = A … 13 = K.
- `card_points` out 4: A = 1, 2..10 = face value, J/Q/K = 10.
- `card_is_ace` out 1: high when `card_rank` is 1.
- `hole_card` out 1: high with the fourth opening card (dealer's hidden card).
- `deal_done` out 1: one-cycle strobe, coincident with the fourth opening card's `card_valid`.
- `reshuffled` out 1: one-cycle strobe whenever the shoe is restored.
- `cards_left` out 6: cards remaining in the shoe, 0..52.

## Operation
- States:
  - IDLE: accepts requests.
  - SETTLE: waits `SETTLE_CYCLES` cycles.
  - DRAW: samples `rng_value`.
  - EMIT: presents the card.
- Reset values: state IDLE; all rank counts 0; `cards_left` = 52; every other output 0.
- IDLE priority: `shuffle` > `deal_start` > `player_hit` > `dealer_hit`.
  - Only the winning request is accepted.
  - Losing requests, and any request made while `busy` is high, are dropped. Requesters retry after `busy` falls.
- `shuffle` accept: clear rank counts, set `cards_left` = 52, pulse `reshuffled`, remain IDLE.
- `deal_start` accept:
  - Reshuffle in the same cycle (counts cleared, `reshuffled` pulsed) if `cards_left` < `RESHUFFLE_THRESH`.
  - Set the sequence index to 0 and go to SETTLE.
- Hit accept:
  - Reshuffle in the same cycle if `cards_left` = 0.
  - Latch the destination and go to SETTLE.
- SETTLE: the counter loads `SETTLE_CYCLES - 1` on entry and goes to DRAW when it reaches 0.
- DRAW:
  - The sample is rejected if the rank is illegal or its count is 4. On rejection, stay in DRAW and resample next cycle.
  - Otherwise register rank/points/ace, increment the rank count, decrement `cards_left`, and go to EMIT.
- EMIT:
  - Assert `card_valid` for one cycle.
  - Deal destination by index: 0 → P, 1 → D, 2 → P, 3 → D.
  - For indexes 0..2, increment the index and return to SETTLE.
  - For index 3, assert `hole_card` and `deal_done`, then return to IDLE.
  - For hits, return to IDLE.
- Card outputs hold their last value between strobes.
- Rank counts are 3 bits each and saturate at 4. `cards_left` never underflows because a draw always follows a reshuffle at 0.

## Timing
- Request accepted in cycle T: SETTLE occupies T+1 .. T+`SETTLE_CYCLES`, DRAW is at T+`SETTLE_CYCLES`+1, and `card_valid` is at T+`SETTLE_CYCLES`+2.
- Each rejected sample adds one cycle.
- Opening-deal minimum: 4 × (`SETTLE_CYCLES` + 2) cycles from accept to `deal_done`.
- `busy` rises at T+1 and falls the cycle after the final EMIT. A request in that cycle is accepted (back-to-back hits allowed).
- `rst` mid-deal: the next edge returns to IDLE with reset values. No partial `deal_done` is issued.

## Configuration
- `DEAL_SHOE_TRACK_EN` defined: rank counts, `cards_left` decrement, and all reshuffle logic are as above.
- `DEAL_SHOE_TRACK_EN` undefined (infinite deck):
  - No rank counts; only illegal ranks are rejected.
  - `cards_left` is constant 52.
  - `reshuffled` is constant 0.
  - `shuffle` is ignored.

## Test plan
- Reset with `SETTLE_CYCLES`=4 → `busy`=0, `card_valid`=0, `cards_left`=52, all card outputs 0.
- `rng_value` held at 7, `deal_start` at T → `card_valid` at T+6, T+12, T+18, T+24 with destinations P, D, P, D, rank 7, points 7. `hole_card` and `deal_done` at T+24. `cards_left`=48.
- `player_hit` with `rng_value`=0 for the first 3 DRAW cycles, then 12 → `card_valid` at T+9, rank 12, points 10, `card_is_ace`=0.
- Four hits with `rng_value`=1 (each `card_is_ace`=1, points 1), then a fifth hit with `rng_value`=1 → stays in DRAW with `busy`=1 until `rng_value`=2, then emits rank 2.
- `player_hit` and `dealer_hit` in the same cycle, then `dealer_hit` while busy → one player card only; both dealer requests dropped.
- Bring `cards_left` to 11, then `deal_start` → `reshuffled` pulses in the accept cycle; `cards_left` = 52, then 48 at `deal_done`.
